// File: rtl/pipelined_carry_skip_adder_pkg.sv
// Shared constants and stage record for the pipelined carry-skip adder.
// The record below is laid out at the default width; the top mirrors it at its own WIDTH.
package pipelined_carry_skip_adder_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_BLOCK = 4;

    typedef struct packed {
        logic                 vld;
        logic [DEF_WIDTH-1:0] a;
        logic [DEF_WIDTH-1:0] b;
        logic [DEF_WIDTH-1:0] sum;
        logic                 carry;
        logic                 cmsb;
    } stage_t;

endpackage

// File: rtl/pipelined_carry_skip_adder_if.sv
// Valid/ready operand and result bus of the pipelined carry-skip adder.
interface pipelined_carry_skip_adder_if
    import pipelined_carry_skip_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_carry_skip_adder_csa_block.sv
// One combinational BLOCK-bit slice: ripple sum plus a skip mux on the block carry-out.
module csa_block
    import pipelined_carry_skip_adder_pkg::*;
#(
    parameter int BLOCK = DEF_BLOCK
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             ci,
    output logic [BLOCK-1:0] s,
    output logic             co,
    output logic             cm
);
    logic [BLOCK:0] c;
    logic           prop;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < BLOCK; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & c[i]);
        end
    end

    // When every bit propagates the incoming carry bypasses the ripple chain.
    assign prop = &(a ^ b);
    assign co   = prop ? ci : c[BLOCK];
    assign cm   = c[BLOCK-1];
endmodule

// File: rtl/pipelined_carry_skip_adder.sv
// Adder pipelined one carry-skip block per stage, with per-stage valid and backpressure.
module pipelined_carry_skip_adder
    import pipelined_carry_skip_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BLOCK = DEF_BLOCK
) (
    input logic                         clk,
    input logic                         rst,
    pipelined_carry_skip_adder_if.slave bus
);
    localparam int NBLK = WIDTH / BLOCK;

    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] sum;
        logic             carry;
        logic             cmsb;
    } stage_rec_t;

    if ((WIDTH % BLOCK) != 0 || WIDTH < BLOCK) begin : g_bad_width
        $error("pipelined_carry_skip_adder: WIDTH must be a non-zero multiple of BLOCK");
    end

    logic [NBLK-1:0] vld;
    logic [NBLK-1:0] adv;
    logic [NBLK-1:0] ld;
    logic            rdy_en;
    logic            in_rdy;

    // Holds in_ready low through reset and for the first edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdy_en <= 1'b0;
        else     rdy_en <= 1'b1;
    end

    always_comb begin
        adv         = '0;
        adv[NBLK-1] = vld[NBLK-1] & bus.out_ready;
        for (int k = NBLK - 2; k >= 0; k--) begin
            adv[k] = vld[k] & (~vld[k+1] | adv[k+1]);
        end
    end

    assign in_rdy       = rdy_en & (~vld[0] | adv[0]);
    assign bus.in_ready = in_rdy;

    for (genvar k = 0; k < NBLK; k++) begin : g_stage
        stage_rec_t       stg_p;
        stage_rec_t       nxt;
        logic [WIDTH-1:0] in_a;
        logic [WIDTH-1:0] in_b;
        logic [WIDTH-1:0] in_sum;
        logic             in_c;
        logic [BLOCK-1:0] blk_s;
        logic             blk_co;
        logic             blk_cm;

        // Stage 0 takes raw operands, with b inverted and carry forced for subtract.
        if (k == 0) begin : g_head
            assign in_a   = bus.a;
            assign in_b   = bus.sub ? ~bus.b : bus.b;
            assign in_c   = bus.sub | bus.cin;
            assign in_sum = '0;
            assign ld[0]  = bus.in_valid & in_rdy;
        end else begin : g_body
            assign in_a   = g_stage[k-1].stg_p.a;
            assign in_b   = g_stage[k-1].stg_p.b;
            assign in_c   = g_stage[k-1].stg_p.carry;
            assign in_sum = g_stage[k-1].stg_p.sum;
            assign ld[k]  = adv[k-1];
        end

        csa_block #(.BLOCK(BLOCK)) u_blk (
            .a  (in_a[k*BLOCK +: BLOCK]),
            .b  (in_b[k*BLOCK +: BLOCK]),
            .ci (in_c),
            .s  (blk_s),
            .co (blk_co),
            .cm (blk_cm)
        );

        always_comb begin
            nxt                       = '0;
            nxt.vld                   = 1'b1;
            nxt.a                     = in_a;
            nxt.b                     = in_b;
            nxt.sum                   = in_sum;
            nxt.sum[k*BLOCK +: BLOCK] = blk_s;
            nxt.carry                 = blk_co;
            nxt.cmsb                  = blk_cm;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stg_p.vld <= 1'b0;
            end else if (ld[k]) begin
                stg_p <= nxt;
            end else if (adv[k]) begin
                stg_p.vld <= 1'b0;
            end
        end

        assign vld[k] = stg_p.vld;

        if (k < NBLK - 1) begin : g_mid
            logic unused_cm;
            assign unused_cm = stg_p.cmsb;
        end
    end

    stage_rec_t last;
    logic       unused_tail;

    assign last          = g_stage[NBLK-1].stg_p;
    assign unused_tail   = ^{last.a, last.b};
    assign bus.out_valid = last.vld;
    assign bus.sum       = last.vld ? last.sum : '0;
    assign bus.cout      = last.vld & last.carry;
    assign bus.ovf       = last.vld & (last.carry ^ last.cmsb);
endmodule

// File: tb/tb_pipelined_carry_skip_adder.sv
// Randomized and directed bench for pipelined_carry_skip_adder against an arithmetic reference.
module tb_pipelined_carry_skip_adder;
    import pipelined_carry_skip_adder_pkg::*;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pipelined_carry_skip_adder_if #(.WIDTH(W)) bus ();

    pipelined_carry_skip_adder #(.WIDTH(W), .BLOCK(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    int          n_out = 0;
    logic [17:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, cout, sum} from integer arithmetic on the operand values.
    function automatic logic [17:0] ref_add(input logic [15:0] a, input logic [15:0] b,
                                            input logic cin, input logic sub);
        int   ua, ub, us, sa, sb, ss;
        logic co, ov;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            us = ua - ub;
            co = (ua >= ub);
            ss = sa - sb;
        end else begin
            us = ua + ub + int'(cin);
            co = (us > 65535);
            ss = sa + sb + int'(cin);
        end
        ov = (ss > 32767) || (ss < -32768);
        return {ov, co, 16'(us)};
    endfunction

    always @(negedge clk) begin : mon
        logic [17:0] e;
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("stray_result", {31'd0, bus.out_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sum", 32'(bus.sum), 32'(e[15:0]));
                    chk("cout", 32'(bus.cout), 32'(e[16]));
                    chk("ovf", 32'(bus.ovf), 32'(e[17]));
                    n_out++;
                end
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(ref_add(bus.a, bus.b, bus.cin, bus.sub));
        end
    end

    task automatic rand_ops();
        bus.a   = 16'($urandom);
        bus.b   = 16'($urandom);
        bus.cin = 1'($urandom);
        bus.sub = 1'($urandom);
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
        bit fired;
        int g;
        g = 0;
        bus.in_valid = 1'b1;
        bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub;
        do begin
            @(negedge clk);
            fired = bus.in_ready;
            @(posedge clk);
            #1;
            g++;
        end while (!fired && g < 50);
        bus.in_valid = 1'b0;
        if (!fired) chk("send_accept", {31'd0, bus.in_ready}, 32'd1);
    endtask

    task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic cin, input logic sub,
                            input logic [15:0] es, input logic ec, input logic eo);
        int lat;
        send(a, b, cin, sub);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 20);
        chk({tag, "_latency"}, lat, 32'd4);
        chk({tag, "_sum"}, 32'(bus.sum), 32'(es));
        chk({tag, "_cout"}, 32'(bus.cout), 32'(ec));
        chk({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
        @(posedge clk);
        #1;
    endtask

    task automatic stream_random(input int n, output int cycles);
        int sent;
        bit fired;
        sent   = 0;
        cycles = 0;
        rand_ops();
        bus.in_valid = 1'b1;
        while (sent < n && cycles < n * 10) begin
            @(negedge clk);
            fired = bus.in_ready;
            @(posedge clk);
            #1;
            cycles++;
            if (fired) begin
                sent++;
                rand_ops();
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk({tag, "_drained"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        int          cyc, acc, base, seen;
        bit          fired, pend;
        logic [17:0] held;

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_cout", {31'd0, bus.cout}, 32'd0);
        chk("rst_ovf", {31'd0, bus.ovf}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);

        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("in_ready_pre_edge", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        chk("in_ready_post_edge", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;

        directed("add_small", 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);
        directed("add_ones",  16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        directed("full_skip", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        directed("sub_neg",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        drain("directed");

        base = n_out;
        stream_random(20, cyc);
        chk("b2b_cycles", cyc, 32'd20);
        drain("b2b");
        chk("b2b_results", n_out - base, 32'd20);

        // Backpressure: fill from empty with the consumer stalled.
        bus.out_ready = 1'b0;
        acc  = 0;
        held = '0;
        rand_ops();
        bus.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            fired = bus.in_ready;
            if (c == 4) held = {bus.ovf, bus.cout, bus.sum};
            if (c == 9) begin
                chk("stall_hold", 32'({bus.ovf, bus.cout, bus.sum}), 32'(held));
                chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
                chk("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
            end
            @(posedge clk);
            #1;
            if (fired) begin
                acc++;
                rand_ops();
            end
        end
        chk("stall_accepts", acc, 32'd4);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("full_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        drain("stall");

        // Random valid/ready mix, data held while waiting for acceptance.
        pend = 1'b0;
        for (int c = 0; c < 80; c++) begin
            bus.out_ready = 1'($urandom);
            if (!pend && $urandom_range(0, 3) != 0) begin
                rand_ops();
                pend = 1'b1;
            end
            bus.in_valid = pend;
            @(negedge clk);
            if (pend && bus.in_ready) pend = 1'b0;
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain("mixed");

        // Reset with three results in flight and the head one on the output.
        bus.out_ready = 1'b0;
        stream_random(3, cyc);
        @(posedge clk);
        #1;
        chk("pre_rst_out_valid", {31'd0, bus.out_valid}, 32'd1);
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_sum", 32'(bus.sum), 32'd0);
        chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("post_rst_stale", seen, 32'd0);
        @(posedge clk);
        #1;
        directed("post_rst", 16'h1234, 16'h0FF0, 1'b0, 1'b0, 16'h2224, 1'b0, 1'b0);
        drain("final");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
